load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_ADDR_W, default 16, RAM word-address width; byte address width is WORD_ADDR_W+2.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 req_signed  input  1  sign-extend load result.
REQ-010 req_addr  input  WORD_ADDR_W+2  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse, loads and stores.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  illegal size; qualified by resp_valid.
REQ-015 ram_enable, ram_we  output  1 each  RAM strobes.
REQ-016 ram_bank_select  output  4  byte-lane enables, bit n = bits 8n+7:8n.
REQ-017 ram_addr  output  WORD_ADDR_W  RAM word address.
REQ-018 ram_di  output  32  lane-positioned write data.
REQ-019 ram_do  input  32  RAM read data, valid the cycle after an enabled access; unselected lanes are stale.

Function
REQ-020 States SHALL be IDLE, ACC1, ACC2, RESP; req_ready = 1 only in IDLE with reset low.
REQ-021 Handshake: request accepted on an edge with req_valid & req_ready; inputs need not hold after that edge.
REQ-022 Offset o = req_addr[1:0], n = 1/2/4 bytes; request is split iff o+n > 4.
REQ-023 IDLE->ACC1 on legal accept; IDLE->RESP with resp_err=1, no RAM access, on size 3.
REQ-024 ACC1: ram_enable=1, ram_addr = req_addr[top:2], bank_select = (n-byte mask << o)[3:0], ram_di = wdata << 8*o; next ACC2 if split, else RESP.
REQ-025 ACC2: ram_addr = first word address + 1 (wraps to 0 at all-ones), bank_select = mask >> (4-o), ram_di = wdata >> 8*(4-o); capture ram_do (first word) into holding register; next RESP.
REQ-026 RAM outputs SHALL come from registers; ram_enable and ram_we are 0 outside ACC1/ACC2; ram_we = captured req_we.
REQ-027 RESP: resp_valid=1 for one cycle; load data = ({ram_do, hold} if split else {32'b0, ram_do}) >> 8*o, low n bytes, sign- or zero-extended per req_signed; next IDLE.
REQ-028 Latency accept edge to resp_valid: 2 cycles aligned/unsplit, 3 split, 1 illegal; no response backpressure.
REQ-029 req_valid in non-IDLE states SHALL be ignored; next accept earliest in the cycle after RESP.

Reset
REQ-030 Reset SHALL force IDLE, ram_enable=0, ram_we=0, bank_select=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0 while asserted.
REQ-031 Reset mid-operation SHALL abort the request: no further RAM strobes, no response; req_ready=1 the first cycle after reset deasserts.

Structure
REQ-032 Shared package SHALL hold size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and state encodings.
REQ-033 One sub-module ls_align (combinational: lane mask, write shift, read extract/extend) SHALL be used; FSM and registers stay in load_store_unit.

Verification
REQ-034 Store word 0x11223344 at 0x0008, then load word 0x0008 -> ram_addr 2, bank_select 1111; resp_rdata 0x11223344 two cycles after accept.
REQ-035 Load signed byte at 0x0003 with RAM byte 0x80 -> bank_select 1000, resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Store half 0xBEEF at 0x0007 -> ACC1 addr 1 mask 1000 di[31:24]=0xEF; ACC2 addr 2 mask 0001 di[7:0]=0xBE; load back -> 0x0000BEEF after 3 cycles.
REQ-037 Word load at byte address 0x3FFFE -> second access ram_addr 0x0000, mask 0011; data assembled correctly.
REQ-038 req_size=3 -> no ram_enable, resp_valid with resp_err=1 one cycle after accept.
REQ-039 Reset asserted during ACC2 -> no resp_valid, RAM strobes low next cycle, req_ready high the cycle after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state encodings and the byte-lane mask helper.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Right-aligned byte mask covering the access size (empty for illegal size).
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      SZ_WORD: size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_ls_align.sv
// ls_align: combinational lane alignment for the load/store unit.
// Ports:
//   size, offset, is_signed - access description
//   wdata                   - right-aligned store data
//   rd_word, rd_hold        - current RAM word and held first word (split loads)
//   split                   - access crosses a word boundary
//   mask_lo/mask_hi         - lane enables for first/second word
//   di_lo/di_hi             - lane-positioned write data for first/second word
//   load_data               - extracted, extended load result
module ls_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  input  logic [31:0] rd_hold,
  output logic        split,
  output logic [3:0]  mask_lo,
  output logic [3:0]  mask_hi,
  output logic [31:0] di_lo,
  output logic [31:0] di_hi,
  output logic [31:0] load_data
);

  logic [7:0]  mask8;
  logic [63:0] di64;
  logic [63:0] rd64;
  logic [31:0] shifted;

  // Shift into a two-word window; the upper half spills into the next word.
  always_comb begin
    mask8   = 8'(size_mask(size)) << offset;
    di64    = 64'(wdata) << {offset, 3'b000};
    mask_lo = mask8[3:0];
    mask_hi = mask8[7:4];
    di_lo   = di64[31:0];
    di_hi   = di64[63:32];
    split   = |mask8[7:4];
    rd64    = split ? {rd_word, rd_hold} : {32'h0, rd_word};
    shifted = 32'(rd64 >> {offset, 3'b000});
    case (size)
      SZ_BYTE: load_data = is_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
      SZ_HALF: load_data = is_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side byte/half/word loads and stores onto a 32-bit
// word RAM with byte-lane enables; misaligned accesses that cross a word
// boundary are split into two RAM accesses.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   req_*                 - request channel (valid/ready handshake)
//   resp_valid/rdata/err  - one-cycle completion pulse with load data
//   ram_*                 - registered RAM strobes/address/data, ram_do read data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [WORD_ADDR_W+1:0] req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   ram_enable,
  output logic                   ram_we,
  output logic [3:0]             ram_bank_select,
  output logic [WORD_ADDR_W-1:0] ram_addr,
  output logic [31:0]            ram_di,
  input  logic [31:0]            ram_do
);

  state_t                 state, state_next;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [1:0]             offset_q, size_q;
  logic                   signed_q, we_q;
  logic [31:0]            wdata_q, hold_q;

  logic                   idle, accept, illegal;
  logic                   split;
  logic [3:0]             mask_lo, mask_hi;
  logic [31:0]            di_lo, di_hi, load_data;

  logic                   ram_enable_next, ram_we_next;
  logic [3:0]             bank_next;
  logic [WORD_ADDR_W-1:0] ram_addr_next;
  logic [31:0]            ram_di_next;

  assign idle      = (state == ST_IDLE);
  assign accept    = idle && req_valid;
  assign illegal   = (req_size == SZ_ILLEGAL);
  assign req_ready = idle && !reset;

  // In IDLE the aligner sees the live request; afterwards the captured copy.
  ls_align u_align (
    .size      (idle ? req_size : size_q),
    .offset    (idle ? req_addr[1:0] : offset_q),
    .is_signed (signed_q),
    .wdata     (idle ? req_wdata : wdata_q),
    .rd_word   (ram_do),
    .rd_hold   (hold_q),
    .split     (split),
    .mask_lo   (mask_lo),
    .mask_hi   (mask_hi),
    .di_lo     (di_lo),
    .di_hi     (di_hi),
    .load_data (load_data)
  );

  // Next state and next values of the registered RAM strobes.
  always_comb begin
    state_next      = state;
    ram_enable_next = 1'b0;
    ram_we_next     = 1'b0;
    bank_next       = 4'b0000;
    ram_addr_next   = ram_addr;
    ram_di_next     = ram_di;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_next = ST_RESP;
          end else begin
            state_next      = ST_ACC1;
            ram_enable_next = 1'b1;
            ram_we_next     = req_we;
            bank_next       = mask_lo;
            ram_addr_next   = req_addr[WORD_ADDR_W+1:2];
            ram_di_next     = di_lo;
          end
        end
      end
      ST_ACC1: begin
        if (split) begin
          state_next      = ST_ACC2;
          ram_enable_next = 1'b1;
          ram_we_next     = we_q;
          bank_next       = mask_hi;
          ram_addr_next   = addr_q + WORD_ADDR_W'(1);
          ram_di_next     = di_hi;
        end else begin
          state_next = ST_RESP;
        end
      end
      ST_ACC2: state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      ram_enable      <= 1'b0;
      ram_we          <= 1'b0;
      ram_bank_select <= 4'b0000;
      ram_addr        <= '0;
      ram_di          <= 32'h0;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      addr_q          <= '0;
      offset_q        <= 2'b00;
      size_q          <= SZ_BYTE;
      signed_q        <= 1'b0;
      we_q            <= 1'b0;
      wdata_q         <= 32'h0;
      hold_q          <= 32'h0;
    end else begin
      state           <= state_next;
      ram_enable      <= ram_enable_next;
      ram_we          <= ram_we_next;
      ram_bank_select <= bank_next;
      ram_addr        <= ram_addr_next;
      ram_di          <= ram_di_next;
      resp_valid      <= (state_next == ST_RESP);
      resp_err        <= accept && illegal;
      if (accept) begin
        addr_q   <= req_addr[WORD_ADDR_W+1:2];
        offset_q <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
      end
      // First word of a split access arrives while in ACC2.
      if (state == ST_ACC2) hold_q <= ram_do;
    end
  end

  // Load data is read straight off ram_do during the response cycle.
  assign resp_rdata = (resp_valid && !resp_err && !we_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-lane RAM model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [17:0] req_addr = 18'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_enable, ram_we;
  logic [3:0]  ram_bank_select;
  logic [15:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_do = 32'h0;

  logic [31:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  load_store_unit #(.WORD_ADDR_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .ram_enable      (ram_enable),
    .ram_we          (ram_we),
    .ram_bank_select (ram_bank_select),
    .ram_addr        (ram_addr),
    .ram_di          (ram_di),
    .ram_do          (ram_do)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: lane-masked writes, read data one cycle later.
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_we) begin
        for (int i = 0; i < 4; i++)
          if (ram_bank_select[i]) mem[ram_addr][8*i +: 8] <= ram_di[8*i +: 8];
      end
      ram_do <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one accept edge, then scramble the inputs.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [17:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_signed = sgn;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 18'h2AAAA;
    req_wdata = 32'hDEADBEEF;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_en",     32'(ram_enable), 32'd0);
    chk("rst_we",     32'(ram_we), 32'd0);
    chk("rst_bank",   32'(ram_bank_select), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata",  resp_rdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Preload word 0 and the top word through the unit
    issue(1'b1, 2'd2, 1'b0, 18'h00000, 32'h80123456);
    tick(); tick();
    issue(1'b1, 2'd2, 1'b0, 18'h3FFFC, 32'hAABB1234);
    chk("pre_top_addr", 32'(ram_addr), 32'h0000FFFF);
    tick(); tick();

    // Store word 0x11223344 at 0x0008
    issue(1'b1, 2'd2, 1'b0, 18'h00008, 32'h11223344);
    chk("sw_en",   32'(ram_enable), 32'd1);
    chk("sw_we",   32'(ram_we), 32'd1);
    chk("sw_addr", 32'(ram_addr), 32'd2);
    chk("sw_bank", 32'(ram_bank_select), 32'hF);
    chk("sw_di",   ram_di, 32'h11223344);
    chk("sw_busy", 32'(req_ready), 32'd0);
    tick();
    chk("sw_rvalid", 32'(resp_valid), 32'd1);
    chk("sw_rdata",  resp_rdata, 32'h0);
    chk("sw_en_off", 32'(ram_enable), 32'd0);
    tick();
    chk("sw_pulse", 32'(resp_valid), 32'd0);
    chk("sw_ready", 32'(req_ready), 32'd1);

    // Load word from 0x0008; a request while busy must be ignored
    issue(1'b0, 2'd2, 1'b0, 18'h00008, 32'h0);
    chk("lw_we",   32'(ram_we), 32'd0);
    chk("lw_addr", 32'(ram_addr), 32'd2);
    chk("lw_bank", 32'(ram_bank_select), 32'hF);
    req_valid = 1'b1;
    req_size  = 2'd3;
    tick();
    req_valid = 1'b0;
    chk("lw_rvalid", 32'(resp_valid), 32'd1);
    chk("lw_err",    32'(resp_err), 32'd0);
    chk("lw_rdata",  resp_rdata, 32'h11223344);
    tick();

    // Signed and unsigned byte loads at 0x0003
    issue(1'b0, 2'd0, 1'b1, 18'h00003, 32'h0);
    chk("lbs_bank", 32'(ram_bank_select), 32'b1000);
    chk("lbs_addr", 32'(ram_addr), 32'd0);
    tick();
    chk("lbs_rdata", resp_rdata, 32'hFFFFFF80);
    tick();
    issue(1'b0, 2'd0, 1'b0, 18'h00003, 32'h0);
    tick();
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    tick();

    // Split half store 0xBEEF at 0x0007
    issue(1'b1, 2'd1, 1'b0, 18'h00007, 32'h0000BEEF);
    chk("sh_a1_addr", 32'(ram_addr), 32'd1);
    chk("sh_a1_bank", 32'(ram_bank_select), 32'b1000);
    chk("sh_a1_di",   32'(ram_di[31:24]), 32'hEF);
    tick();
    chk("sh_a2_en",   32'(ram_enable), 32'd1);
    chk("sh_a2_addr", 32'(ram_addr), 32'd2);
    chk("sh_a2_bank", 32'(ram_bank_select), 32'b0001);
    chk("sh_a2_di",   32'(ram_di[7:0]), 32'hBE);
    chk("sh_a2_nresp", 32'(resp_valid), 32'd0);
    tick();
    chk("sh_rvalid", 32'(resp_valid), 32'd1);
    tick();

    // Split half load back: response three cycles after accept
    issue(1'b0, 2'd1, 1'b0, 18'h00007, 32'h0);
    chk("lh_c1_nresp", 32'(resp_valid), 32'd0);
    tick();
    chk("lh_c2_nresp", 32'(resp_valid), 32'd0);
    tick();
    chk("lh_rvalid", 32'(resp_valid), 32'd1);
    chk("lh_rdata",  resp_rdata, 32'h0000BEEF);
    tick();

    // Word load at 0x3FFFE wraps to word 0 for the second access
    issue(1'b0, 2'd2, 1'b0, 18'h3FFFE, 32'h0);
    chk("wrap_a1_addr", 32'(ram_addr), 32'h0000FFFF);
    chk("wrap_a1_bank", 32'(ram_bank_select), 32'b1100);
    tick();
    chk("wrap_a2_addr", 32'(ram_addr), 32'h0);
    chk("wrap_a2_bank", 32'(ram_bank_select), 32'b0011);
    tick();
    chk("wrap_rdata", resp_rdata, 32'h3456AABB);
    tick();

    // Illegal size: error response one cycle after accept, no RAM access
    issue(1'b0, 2'd3, 1'b0, 18'h00004, 32'h0);
    chk("ill_rvalid", 32'(resp_valid), 32'd1);
    chk("ill_err",    32'(resp_err), 32'd1);
    chk("ill_en",     32'(ram_enable), 32'd0);
    chk("ill_rdata",  resp_rdata, 32'h0);
    tick();
    chk("ill_pulse", 32'(resp_valid), 32'd0);
    chk("ill_ready", 32'(req_ready), 32'd1);

    // Reset during ACC2 aborts the request
    issue(1'b0, 2'd1, 1'b0, 18'h00007, 32'h0);
    tick();
    chk("abort_in_acc2", 32'(ram_enable), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_en",     32'(ram_enable), 32'd0);
    chk("abort_bank",   32'(ram_bank_select), 32'd0);
    chk("abort_rvalid", 32'(resp_valid), 32'd0);
    chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    tick();
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    chk("abort_no_en",   32'(ram_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
